dr_cmp_seq: RTL

// - Synchronous sequencer for a dual-rail (DR) W-bit magnitude comparator built from mapped cells.
// - Alternates all-0 / all-1 spacers between code words (spacer-inverter protocol).
// - Converts single-rail operands to DR, waits for DR completion, captures gt/eq.
// - Sits between the clocked host and the asynchronous comparator datapath.

---
 rtl/dr_cmp_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dr_cmp_seq.sv
`default_nettype none
// ============================================================================
// Module   : dr_cmp_seq
// Brief    : Clocked sequencer for a dual-rail magnitude comparator using
//            alternating-spacer return-to-spacer handshaking.
// Option   : DR_TIMEOUT_EN enables the per-phase watchdog and sticky err_o.
// Revision : 1.0  initial release
// ============================================================================
module dr_cmp_seq #(
  parameter int W      = 8,
  parameter int TO_CYC = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid_i,
  output logic         op_ready_o,
  input  logic [W-1:0] op_a_i,
  input  logic [W-1:0] op_b_i,
  output logic [W-1:0] dp_a_t_o,
  output logic [W-1:0] dp_a_f_o,
  output logic [W-1:0] dp_b_t_o,
  output logic [W-1:0] dp_b_f_o,
  input  logic [1:0]   dp_r_t_i,
  input  logic [1:0]   dp_r_f_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic         res_gt_o,
  output logic         res_eq_o,
  output logic         busy_o,
  output logic         err_o
);

  if (TO_CYC < 1) begin : g_to_check
    $error("dr_cmp_seq: TO_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_IDLE   = 2'd1,
    ST_EVAL   = 2'd2,
    ST_RTZ    = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic         sp_q, sp_d;
  logic [3:0]   sync1_q, sync2_q;  // {t[1:0], f[1:0]}
  logic         cond_q;
  logic [W-1:0] at_q, at_d, af_q, af_d, bt_q, bt_d, bf_q, bf_d;
  logic         res_valid_q, res_valid_d, res_gt_q, res_gt_d, res_eq_q, res_eq_d;

  logic w_spc, w_cw, w_cond, w_hold, w_accept, w_timeout;

  assign w_spc  = (sync2_q == {4{sp_q}});
  assign w_cw   = ((sync2_q[3:2] ^ sync2_q[1:0]) == 2'b11);
  assign w_cond = (state_q == ST_EVAL) ? w_cw : w_spc;
  // A condition must be seen on two consecutive cycles within the same state
  assign w_hold = w_cond & cond_q;

  assign op_ready_o = (state_q == ST_IDLE) && (!res_valid_q || res_ready_i);
  assign w_accept   = op_valid_i && op_ready_o;

`ifdef DR_TIMEOUT_EN
  localparam int c_cnt_w = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TO_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic [c_cnt_w-1:0] cnt_q;
  logic               err_q;

  assign w_timeout = (state_q != ST_IDLE) && (cnt_q == c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (w_timeout || (state_d != state_q)) begin
        cnt_q <= '0;
      end else if (state_q != ST_IDLE) begin
        cnt_q <= cnt_q + c_cnt_one;
      end
      if (w_timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    at_d        = at_q;
    af_d        = af_q;
    bt_d        = bt_q;
    bf_d        = bf_q;
    res_valid_d = res_valid_q;
    res_gt_d    = res_gt_q;
    res_eq_d    = res_eq_q;

    if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      ST_SETTLE: if (w_hold) state_d = ST_IDLE;
      ST_IDLE: begin
        if (w_accept) begin
          at_d    = op_a_i;
          af_d    = ~op_a_i;
          bt_d    = op_b_i;
          bf_d    = ~op_b_i;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        // Capture overrides a same-cycle consume of the previous result
        if (w_hold && !w_timeout) begin
          res_valid_d = 1'b1;
          res_gt_d    = sync2_q[3];
          res_eq_d    = sync2_q[2];
          sp_d        = ~sp_q;
          at_d        = {W{~sp_q}};
          af_d        = {W{~sp_q}};
          bt_d        = {W{~sp_q}};
          bf_d        = {W{~sp_q}};
          state_d     = ST_RTZ;
        end
      end
      ST_RTZ: if (w_hold) state_d = ST_IDLE;
      default: state_d = ST_SETTLE;
    endcase

    if (w_timeout) begin
      state_d = ST_SETTLE;
      sp_d    = 1'b0;
      at_d    = '0;
      af_d    = '0;
      bt_d    = '0;
      bf_d    = '0;
    end
  end

  // Synchronisers reset to all-ones so stale contents never mimic the 0-spacer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SETTLE;
      sp_q        <= 1'b0;
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      cond_q      <= 1'b0;
      at_q        <= '0;
      af_q        <= '0;
      bt_q        <= '0;
      bf_q        <= '0;
      res_valid_q <= 1'b0;
      res_gt_q    <= 1'b0;
      res_eq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      sync1_q     <= {dp_r_t_i, dp_r_f_i};
      sync2_q     <= sync1_q;
      cond_q      <= (state_d == state_q) ? w_cond : 1'b0;
      at_q        <= at_d;
      af_q        <= af_d;
      bt_q        <= bt_d;
      bf_q        <= bf_d;
      res_valid_q <= res_valid_d;
      res_gt_q    <= res_gt_d;
      res_eq_q    <= res_eq_d;
    end
  end

  assign dp_a_t_o    = at_q;
  assign dp_a_f_o    = af_q;
  assign dp_b_t_o    = bt_q;
  assign dp_b_f_o    = bf_q;
  assign res_valid_o = res_valid_q;
  assign res_gt_o    = res_gt_q;
  assign res_eq_o    = res_eq_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
